// File: rtl/ppu_pkg.sv
// Shared PPU definitions: palette colour type, black constant and the
// backdrop mirroring helper used by every palette address path.
package ppu_pkg;

    localparam int unsigned PAL_DW = 6;

    typedef logic [PAL_DW-1:0] pal_color_t;

    localparam pal_color_t PAL_BLACK = 6'h0F;

    // Backdrop aliasing: the top address bit survives only when addr[1:0] != 0,
    // so $3F10/$3F14/$3F18/$3F1C land on $3F00/$3F04/$3F08/$3F0C.
    function automatic logic [31:0] pal_mirror(input logic [31:0] addr,
                                               input int unsigned aw);
        logic [31:0] low_mask;
        logic [31:0] top_bit;
        logic        keep_top;
        low_mask = (32'd1 << (aw - 1)) - 32'd1;
        top_bit  = (addr >> (aw - 1)) & 32'd1;
        keep_top = top_bit[0] & (|addr[1:0]);
        return (addr & low_mask) | (32'(keep_top) << (aw - 1));
    endfunction

endpackage

// File: rtl/palette_mem.sv
// Plain 1W/2R palette array: synchronous write, combinational reads, so a
// same-edge write is never visible to a read sampled on that edge (read-first).
// Contents are never reset.
module palette_mem #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned DW    = 6
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr_a,
    output logic [DW-1:0]            rdata_a_c,
    input  logic [$clog2(DEPTH)-1:0] raddr_b,
    output logic [DW-1:0]            rdata_b_c
);

    logic [DW-1:0] mem [DEPTH];

    // Single write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a_c = mem[raddr_a];
    assign rdata_b_c = mem[raddr_b];

endmodule

// File: rtl/palette_ram_mp.sv
// PPU palette memory: CPU request/ready port, registered render port with
// backdrop mirroring and grayscale masking.
// Optional feature macro PALETTE_INIT_EN: post-reset fill sequencer that
// writes INIT_VAL to every entry and stalls the CPU port while busy.
module palette_ram_mp
    import ppu_pkg::*;
#(
    parameter int unsigned   DEPTH    = 32,
    parameter int unsigned   DW       = 6,
    parameter int unsigned   MIRROR   = 1,
    parameter logic [DW-1:0] INIT_VAL = DW'(PAL_BLACK)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [$clog2(DEPTH)-1:0] cpu_addr,
    input  logic [DW-1:0]            cpu_wdata,
    output logic                     cpu_ready,
    output logic                     cpu_rvalid,
    output logic [DW-1:0]            cpu_rdata,
    input  logic [$clog2(DEPTH)-1:0] ren_addr,
    input  logic                     ren_gray,
    output logic [DW-1:0]            ren_data,
    output logic                     busy
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] cpu_eff;
    logic [AW-1:0] ren_eff;
    logic [AW-1:0] seq_addr;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;
    logic          seq_wr;
    logic          mem_we;
    logic          cpu_acc;

    assign cpu_acc = cpu_req & cpu_ready;

    // Effective address mapping, identical for both ports
    always_comb begin
        cpu_eff = cpu_addr;
        ren_eff = ren_addr;
        if (MIRROR != 0) begin
            cpu_eff = AW'(pal_mirror(32'(cpu_addr), AW));
            ren_eff = AW'(pal_mirror(32'(ren_addr), AW));
        end
    end

`ifdef PALETTE_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} seq_state_t;

    seq_state_t    state;
    seq_state_t    state_nx;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nx;

    // Sequencer state and fill counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Walk every entry once, then hand the array to the CPU for good
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        seq_wr   = 1'b0;
        case (state)
            ST_INIT: begin
                seq_wr = 1'b1;
                cnt_nx = cnt + AW'(1);
                if (cnt == AW'(DEPTH - 1)) begin
                    state_nx = ST_RUN;
                    cnt_nx   = '0;
                end
            end
            ST_RUN:  state_nx = ST_RUN;
            default: state_nx = ST_INIT;
        endcase
    end

    assign seq_addr = cnt;

    // Ready and busy flip on the edge that writes the last entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_ready <= 1'b0;
            busy      <= 1'b1;
        end else begin
            cpu_ready <= (state_nx == ST_RUN);
            busy      <= (state_nx == ST_INIT);
        end
    end
`else
    assign seq_wr   = 1'b0;
    assign seq_addr = '0;
    assign busy     = 1'b0;

    // CPU port opens on the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_ready <= 1'b0;
        end else begin
            cpu_ready <= 1'b1;
        end
    end
`endif

    // Write port arbitration: the fill sequencer owns the array while active
    always_comb begin
        mem_we    = seq_wr | (cpu_acc & cpu_we);
        mem_waddr = cpu_eff;
        mem_wdata = cpu_wdata;
        if (seq_wr) begin
            mem_waddr = seq_addr;
            mem_wdata = INIT_VAL;
        end
    end

    palette_mem #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_mem (
        .clk       (clk),
        .we        (mem_we),
        .waddr     (mem_waddr),
        .wdata     (mem_wdata),
        .raddr_a   (cpu_eff),
        .rdata_a_c (rd_a),
        .raddr_b   (ren_eff),
        .rdata_b_c (rd_b)
    );

    // CPU read return: data captured at the acceptance edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            cpu_rvalid <= cpu_acc & ~cpu_we;
            if (cpu_acc && !cpu_we) begin
                cpu_rdata <= rd_a;
            end
        end
    end

    // Render lookup with grayscale masking in the same stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ren_data <= '0;
        end else if (ren_gray) begin
            ren_data <= rd_b & ~DW'(4'hF);
        end else begin
            ren_data <= rd_b;
        end
    end

endmodule

// File: tb/tb_palette_ram_mp.sv
// Directed bench for palette_ram_mp (DEPTH=32, DW=6, MIRROR=1); follows the
// PALETTE_INIT_EN setting of the build.
module tb_palette_ram_mp;

    logic       clk;
    logic       rst;
    logic       cpu_req;
    logic       cpu_we;
    logic [4:0] cpu_addr;
    logic [5:0] cpu_wdata;
    logic       cpu_ready;
    logic       cpu_rvalid;
    logic [5:0] cpu_rdata;
    logic [4:0] ren_addr;
    logic       ren_gray;
    logic [5:0] ren_data;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    palette_ram_mp #(
        .DEPTH    (32),
        .DW       (6),
        .MIRROR   (1),
        .INIT_VAL (6'h0F)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ren_addr   (ren_addr),
        .ren_gray   (ren_gray),
        .ren_data   (ren_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [5:0] d);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        step();
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [5:0] d, output logic v);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = a;
        step();
        d = cpu_rdata;
        v = cpu_rvalid;
        cpu_req = 1'b0;
    endtask

    initial begin
        logic [5:0] d;
        logic       v;
        logic [5:0] old01;
        logic [5:0] old05;
        int         n;
        logic       early_ready;

        rst       = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        ren_addr  = '0;
        ren_gray  = 1'b0;
        step();
        step();

        chk("rst_ready",  32'(cpu_ready),  32'd0);
        chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_rdata",  32'(cpu_rdata),  32'd0);
        chk("rst_ren",    32'(ren_data),   32'd0);
`ifdef PALETTE_INIT_EN
        chk("rst_busy",   32'(busy),       32'd1);

        rst = 1'b1;
        n = 0;
        early_ready = 1'b0;
        while (n < 100) begin
            step();
            n++;
            if (!busy) break;
            if (cpu_ready) early_ready = 1'b1;
        end
        chk("init_len",      32'(n),           32'd32);
        chk("init_ready",    32'(cpu_ready),   32'd1);
        chk("init_no_ready", 32'(early_ready), 32'd0);

        for (int i = 0; i < 32; i++) begin
            rd(5'(i), d, v);
            chk($sformatf("init_rd_v%0d", i), 32'(v), 32'd1);
            chk($sformatf("init_rd_d%0d", i), 32'(d), 32'h0F);
        end
        step();
        chk("rvalid_drop", 32'(cpu_rvalid), 32'd0);
        old01 = 6'h0F;
        old05 = 6'h0F;
`else
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        step();
        chk("first_ready", 32'(cpu_ready), 32'd1);
        chk("first_busy",  32'(busy),      32'd0);

        wr(5'h1F, 6'h2C);
        chk("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
        rd(5'h1F, d, v);
        chk("rd1f_v", 32'(v), 32'd1);
        chk("rd1f_d", 32'(d), 32'h2C);

        wr(5'h01, 6'h07);
        wr(5'h05, 6'h0A);
        old01 = 6'h07;
        old05 = 6'h0A;
`endif

        // Mirroring: 0x10 aliases 0x00, 0x11 stays distinct from 0x01
        wr(5'h10, 6'h21);
        chk("mir_wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
        ren_addr = 5'h10;
        rd(5'h00, d, v);
        chk("mir_rd_v",  32'(v),        32'd1);
        chk("mir_rd_d",  32'(d),        32'h21);
        chk("mir_ren",   32'(ren_data), 32'h21);
        wr(5'h11, 6'h15);
        rd(5'h01, d, v);
        chk("mir_11_not_01", 32'(d), 32'(old01));
        rd(5'h11, d, v);
        chk("mir_11_rd", 32'(d), 32'h15);

        // Upper-half non-aliased entry on the render port
        ren_addr = 5'h11;
        step();
        chk("ren_11", 32'(ren_data), 32'h15);

        // Collision: render sees the old value on the write edge
        ren_addr = 5'h05;
        step();
        wr(5'h05, 6'h2A);
        chk("col_old", 32'(ren_data), 32'(old05));
        step();
        chk("col_new", 32'(ren_data), 32'h2A);

        // Grayscale masking
        wr(5'h03, 6'h27);
        ren_addr = 5'h03;
        ren_gray = 1'b1;
        step();
        chk("gray_on", 32'(ren_data), 32'h20);
        ren_gray = 1'b0;
        step();
        chk("gray_off", 32'(ren_data), 32'h27);

        // Reset cancels a pending read pulse
        rd(5'h03, d, v);
        chk("pre_rst_v", 32'(v), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_cancel_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_cancel_ren",    32'(ren_data),   32'd0);
        chk("rst_again_ready",   32'(cpu_ready),  32'd0);

`ifdef PALETTE_INIT_EN
        // Held write through INIT, with a reset at counter 17
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 5'h02;
        cpu_wdata = 6'h33;
        step();
        rst = 1'b1;
        repeat (17) step();
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd1);
        step();
        rst = 1'b1;
        n = 0;
        early_ready = 1'b0;
        while (n < 100) begin
            step();
            n++;
            if (!busy) break;
            if (cpu_ready) early_ready = 1'b1;
        end
        chk("reinit_len",      32'(n),           32'd32);
        chk("reinit_no_ready", 32'(early_ready), 32'd0);
        chk("reinit_ready",    32'(cpu_ready),   32'd1);
        step();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        chk("stall_wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
        rd(5'h02, d, v);
        chk("stall_wr_v", 32'(v), 32'd1);
        chk("stall_wr_d", 32'(d), 32'h33);
        rd(5'h05, d, v);
        chk("reinit_05", 32'(d), 32'h0F);
        rd(5'h10, d, v);
        chk("reinit_10", 32'(d), 32'h0F);
`else
        step();
        rst = 1'b1;
        chk("rst2_busy", 32'(busy), 32'd0);
        step();
        chk("rst2_ready", 32'(cpu_ready), 32'd1);
        wr(5'h1F, 6'h3E);
        rd(5'h1F, d, v);
        chk("rst2_rd_v", 32'(v), 32'd1);
        chk("rst2_rd_d", 32'(d), 32'h3E);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/palette_ram_mp.md
# palette_ram_mp

Parametrised, dual-port palette memory for the PPU. It serves the CPU-side $3F00–$3F1F access path through a request/ready handshake and the pixel pipeline through a dedicated read-only render port. It applies the NES backdrop mirroring and grayscale masking in hardware. An optional post-reset sequencer fills the array with a known colour, so no simulation-only file loading is needed.

## Interface
Parameters:
- DEPTH, 32, number of palette entries; power of two, ≥8.
- DW, 6, entry width in bits; ≥4.
- MIRROR, 1, when 1, upper-half entries with addr[1:0]==0 alias the lower half.
- INIT_VAL, 6'h0F, value written to every entry by the init sequencer.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- cpu_req  in  1  CPU access request; held until accepted.
- cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req.
- cpu_addr  in  $clog2(DEPTH)  CPU entry address.
- cpu_wdata  in  DW  CPU write data.
- cpu_ready  out  1  request accepted this cycle when cpu_req && cpu_ready.
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid.
- cpu_rdata  out  DW  CPU read data.
- ren_addr  in  $clog2(DEPTH)  render lookup address; sampled every cycle.
- ren_gray  in  1  grayscale enable (PPUMASK bit 0).
- ren_data  out  DW  registered render colour.
- busy  out  1  init sequencer active.

## Operation
- Address mapping, applied identically on both ports, with AW = $clog2(DEPTH):
  - MIRROR=1: effective address = {addr[AW-1] & |addr[1:0], addr[AW-2:0]}.
  - MIRROR=0: effective address = addr.
- Sequencer states:
  - INIT: entered on reset assertion. A counter walks 0..DEPTH-1 and writes INIT_VAL once per cycle. Moves to RUN after writing entry DEPTH-1.
  - RUN: normal operation. Stays in RUN until the next reset.
- cpu_ready = (state==RUN). A request presented during INIT stalls; nothing is dropped.
- Accepted write: the array is updated at the clock edge. No rvalid pulse is generated.
- Accepted read: cpu_rdata is loaded and cpu_rvalid pulses on the next cycle.
- Render port:
  - ren_data is updated every cycle from the effective ren_addr, including during INIT.
  - During INIT the returned value is the current array content.
  - Grayscale, when ren_gray=1: ren_data = {mem[DW-1:4], 4'b0000}, applied in the same registered stage.
- Collisions:
  - CPU write and render read to the same effective address in the same cycle: render returns the old value (read-first).
  - The CPU port is read-before-write-irrelevant, since it issues one operation per cycle.
- Reset mid-INIT or mid-RUN returns the state to INIT with the counter at 0. Any pending cpu_rvalid is cancelled.

## Timing
- Reset values: cpu_ready=0, cpu_rvalid=0, cpu_rdata=0, ren_data=0, busy=1 (with init compiled in).
- INIT lasts exactly DEPTH cycles after reset deassertion. busy falls and cpu_ready rises on the same edge.
- CPU read latency: 1 cycle from the acceptance edge to cpu_rvalid.
- Render latency: 1 cycle from ren_addr to ren_data, fully pipelined, one result per cycle.
- CPU throughput: one access per cycle in RUN.
- A write followed by a read of the same entry on the next cycle returns the new data.

## Configuration
- PALETTE_INIT_EN defined:
  - INIT sequencer is present, busy and stall behaviour are as above, and contents after INIT are all INIT_VAL.
- PALETTE_INIT_EN undefined:
  - No sequencer, busy tied 0, cpu_ready=1 from the first cycle after reset deassertion.
  - Array contents are undefined until written; the array itself is never reset.

## Structure
- A shared package (ppu_pkg) holds:
  - the colour type (logic [DW-1:0] form, default 6-bit NES colour index);
  - the constant PAL_BLACK = 6'h0F;
  - the helper function pal_mirror(addr) used by both ports and the renderer.
- One sub-module: palette_mem. It is a plain 1W/2R synchronous array with read-first semantics, kept separate so it can be swapped for a vendor RAM. Sequencer, arbitration and masking stay in the top.

## Test plan
- Reset with DEPTH=32 and PALETTE_INIT_EN defined:
  - busy=1 for exactly 32 cycles;
  - CPU reads of all 32 addresses then return 6'h0F with rvalid one cycle after acceptance.
- Mirroring: write 6'h21 to 0x10, then read 0x00 on the CPU port and 0x10 on the render port. Both return 6'h21.
  - Write 6'h15 to 0x11, then read 0x01: returns the previous value, not 6'h15.
- Collision: write 6'h2A to 0x05 while ren_addr=0x05.
  - ren_data next cycle = old value;
  - the following cycle = 6'h2A.
- Grayscale: entry 0x03 = 6'h27 with ren_gray=1 → ren_data = 6'h20. Deassert ren_gray → 6'h27 next cycle.
- Stall and reset mid-INIT:
  - Assert cpu_req write during INIT: it is held off until busy falls, then accepted on that cycle.
  - Assert rst at counter=17: restart gives a full 32-cycle INIT.
- Without PALETTE_INIT_EN: cpu_ready=1 on the first post-reset cycle and busy stays 0. Write/read of 0x1F returns the written value.
